// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry/exit sequencer driving the CSR write port and the PC redirect
module trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        wb_csr_we_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        hold_o,
  output logic        flush_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_MEPC    = 3'd1;
  localparam logic [2:0] WR_MCAUSE  = 3'd2;
  localparam logic [2:0] WR_MSTATUS = 3'd3;
  localparam logic [2:0] WR_MRET    = 3'd4;
  localparam logic [2:0] JUMP       = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [31:0] cause_q, cause_d, pc_q, pc_d, mstatus_q, mstatus_d, mtvec_q, mtvec_d;
  logic        irq_q, irq_d, mret_q, mret_d;
  logic        irq_ext, irq_tmr, exc, accept;
  logic [31:0] trap_pc, ms_trap, ms_mret;
  always_comb begin
    irq_ext   = irq_ext_i & mstatus_i[3];
    irq_tmr   = irq_timer_i & mstatus_i[3];
    exc       = ebreak_i | ecall_i;
    accept    = rst_i & (state_q == IDLE) & inst_valid_i & ~wb_csr_we_i & (exc | mret_i | irq_ext | irq_tmr);
    state_d   = accept ? ((exc | ~mret_i) ? WR_MEPC : WR_MRET) :
                state_q == WR_MEPC ? WR_MCAUSE :
                state_q == WR_MCAUSE ? WR_MSTATUS :
                (state_q == WR_MSTATUS || state_q == WR_MRET) ? JUMP : IDLE;
    cause_d   = accept ? (ebreak_i ? 32'd3 : ecall_i ? 32'd11 : irq_ext ? 32'h8000000B : 32'h80000007) : cause_q;
    pc_d      = accept ? inst_addr_i : pc_q;
    mstatus_d = accept ? mstatus_i : mstatus_q;
    mtvec_d   = accept ? mtvec_i : mtvec_q;
    irq_d     = accept ? ~exc & ~mret_i : irq_q;
    mret_d    = accept ? ~exc & mret_i : mret_q;
  end
  // vectored offset only applies to interrupts; modes 10/11 fall back to direct
  always_comb begin
    trap_pc = {mtvec_q[31:2], 2'b00} + ((mtvec_q[1:0] == 2'b01 && irq_q) ? {25'b0, cause_q[4:0], 2'b00} : 32'h0);
    ms_trap = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
    ms_mret = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
    hold_o      = (state_q == IDLE) ? accept : state_q != JUMP;
    flush_o     = state_q == JUMP;
    jump_flag_o = state_q == JUMP;
    jump_addr_o = state_q != JUMP ? RESET_PC : mret_q ? mepc_i & ~32'h3 : trap_pc;
    csr_we_o    = state_q == WR_MEPC || state_q == WR_MCAUSE || state_q == WR_MSTATUS || state_q == WR_MRET;
    csr_waddr_o = state_q == WR_MEPC ? 12'h341 : state_q == WR_MCAUSE ? 12'h342 :
                  (state_q == WR_MSTATUS || state_q == WR_MRET) ? 12'h300 : 12'h0;
    csr_wdata_o = state_q == WR_MEPC ? pc_q : state_q == WR_MCAUSE ? cause_q :
                  state_q == WR_MSTATUS ? ms_trap : state_q == WR_MRET ? ms_mret : 32'h0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      irq_q     <= 1'b0;
      mret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      irq_q     <= irq_d;
      mret_q    <= mret_d;
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with directed cases then random stimulus
module tb_trap_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct {
    int          cyc;
    bit          jmp;
    bit          use_mepc;
    logic [11:0] a;
    logic [31:0] d;
  } ev_t;
  logic        clk = 0, rst_i = 0;
  logic        iv = 0, ec = 0, eb = 0, mr = 0, ie = 0, it = 0, wb = 0;
  logic [31:0] pc = 0, tv = 0, ep = 0, ms = 0;
  logic        hold_o, flush_o, jump_flag_o, csr_we_o;
  logic [31:0] jump_addr_o, csr_wdata_o;
  logic [11:0] csr_waddr_o;
  int          cyc = 0, vectors = 0, miscompares = 0, free_at = 0;
  bit          exp_hold = 0;
  ev_t         q[$];
  ev_t         e;

  trap_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_valid_i(iv), .inst_addr_i(pc),
    .ecall_i(ec), .ebreak_i(eb), .mret_i(mr), .irq_ext_i(ie), .irq_timer_i(it),
    .wb_csr_we_i(wb), .mtvec_i(tv), .mepc_i(ep), .mstatus_i(ms),
    .hold_o(hold_o), .flush_o(flush_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    vectors++;
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", n, cyc, a, x);
    end
  endtask

  task automatic bad(string n);
    vectors++;
    miscompares++;
    $display("FAIL %s cyc=%0d", n, cyc);
  endtask

  task automatic push(int c, bit j, bit m, logic [11:0] a, logic [31:0] d);
    ev_t n;
    n.cyc = c; n.jmp = j; n.use_mepc = m; n.a = a; n.d = d;
    q.push_back(n);
  endtask

  // reference: trap = 3 writes then redirect, 5 cycles from accept to idle
  task automatic trap(logic [31:0] cause, bit irq);
    logic [31:0] t;
    t = (tv & ~32'h3) + ((tv[1:0] == 2'b01 && irq) ? (cause & 32'h1F) * 32'd4 : 32'h0);
    push(cyc + 1, 0, 0, 12'h341, pc);
    push(cyc + 2, 0, 0, 12'h342, cause);
    push(cyc + 3, 0, 0, 12'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800);
    push(cyc + 4, 1, 0, 12'h0, t);
    free_at = cyc + 5;
  endtask

  task automatic tick();
    bit acc;
    acc = 0;
    if (rst_i && cyc >= free_at && iv && !wb) begin
      acc = 1;
      if (eb) trap(32'd3, 0);
      else if (ec) trap(32'd11, 0);
      else if (mr) begin
        push(cyc + 1, 0, 0, 12'h300, (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880);
        push(cyc + 2, 1, 1, 12'h0, 32'h0);
        free_at = cyc + 3;
      end
      else if (ie && ms[3]) trap(32'h8000000B, 1);
      else if (it && ms[3]) trap(32'h80000007, 1);
      else acc = 0;
    end
    exp_hold = rst_i && (acc || cyc < free_at - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iv = 0; ec = 0; eb = 0; mr = 0; ie = 0; it = 0; wb = 0;
  endtask

  task automatic idle(int n);
    clr();
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      bad("missed_event");
      void'(q.pop_front());
    end
    chk("hold", 32'(hold_o), 32'(exp_hold));
    if (csr_we_o || jump_flag_o) begin
      if (q.size() == 0 || q[0].cyc != cyc) bad("unexpected_event");
      else begin
        e = q.pop_front();
        chk("kind", 32'({csr_we_o, jump_flag_o}), 32'({~e.jmp, e.jmp}));
        if (e.jmp) begin
          chk("flush", 32'(flush_o), 32'd1);
          chk("jump_addr", jump_addr_o, e.use_mepc ? ep & ~32'h3 : e.d);
        end else begin
          chk("waddr", 32'(csr_waddr_o), 32'(e.a));
          chk("wdata", csr_wdata_o, e.d);
        end
      end
    end else begin
      chk("idle_flush", 32'(flush_o), 32'd0);
      chk("idle_waddr", 32'(csr_waddr_o), 32'd0);
      chk("idle_wdata", csr_wdata_o, 32'd0);
      chk("idle_jaddr", jump_addr_o, RESET_PC);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1;
    clr(); iv = 1; ec = 1; pc = 32'h100; tv = 32'h200; ms = 32'h8; tick(); idle(6);
    clr(); iv = 1; it = 1; pc = 32'h80; tv = 32'h401; ms = 32'h8; tick(); idle(6);
    clr(); iv = 1; it = 1; ie = 1; ms = 32'h0; repeat (3) tick(); idle(2);
    clr(); iv = 1; ec = 1; ie = 1; pc = 32'h44; tv = 32'h301; ms = 32'h8; tick(); idle(6);
    clr(); iv = 1; mr = 1; it = 1; ms = 32'h1888; ep = 32'h207; tick(); idle(4);
    clr(); iv = 1; mr = 1; ms = 32'h1880; ep = 32'h104; tick(); idle(4);
    clr(); iv = 1; eb = 1; wb = 1; pc = 32'h300; tv = 32'h100; ms = 32'h0; repeat (2) tick();
    wb = 0; tick(); idle(6);
    clr(); iv = 1; ec = 1; pc = 32'h500; tv = 32'h600; ms = 32'h8; tick(); clr(); tick();
    #2 rst_i = 0;
    #1;
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_we", 32'(csr_we_o), 32'd0);
    chk("rst_waddr", 32'(csr_waddr_o), 32'd0);
    chk("rst_wdata", csr_wdata_o, 32'd0);
    chk("rst_jump", 32'({jump_flag_o, flush_o}), 32'd0);
    chk("rst_jaddr", jump_addr_o, RESET_PC);
    q.delete();
    free_at = cyc;
    exp_hold = 0;
    tick();
    rst_i = 1;
    idle(6);
    repeat (3000) begin
      iv = $urandom_range(0, 3) != 0;
      ec = $urandom_range(0, 9) == 0;
      eb = $urandom_range(0, 11) == 0;
      mr = $urandom_range(0, 9) == 0;
      ie = $urandom_range(0, 4) == 0;
      it = $urandom_range(0, 4) == 0;
      wb = $urandom_range(0, 3) == 0;
      pc = $urandom; tv = $urandom; ep = $urandom; ms = $urandom;
      tick();
    end
    idle(8);
    chk("leftover", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the execute stage and the CSR file. Detects synchronous exceptions (ecall, ebreak), `mret` and level-sensitive timer/external interrupts. Performs trap entry/exit by issuing sequential writes through the CSR file's single write port (mepc, mcause, mstatus), holding the pipeline meanwhile. It then issues a one-cycle PC redirect plus flush to fetch.

## Interface
- `RESET_PC`, 32'h0 — jump_addr_o value while idle/reset.
- `clk_i` in 1 — single clock; all state on rising edge.
- `rst_i` in 1 — reset, asynchronous, active-low (clears on `rst_i==0` regardless of clock).
- `inst_valid_i` in 1 — execute stage holds a valid, non-squashed instruction.
- `inst_addr_i` in 32 — PC of that instruction.
- `ecall_i`, `ebreak_i`, `mret_i` in 1 each — decoded from that instruction; qualified by inst_valid_i.
- `irq_ext_i`, `irq_timer_i` in 1 each — level interrupt requests.
- `wb_csr_we_i` in 1 — writeback is writing a CSR this cycle (port busy).
- `mtvec_i`, `mepc_i`, `mstatus_i` in 32 — current CSR contents from the CSR file.
- `hold_o` out 1 — stall fetch/decode/execute.
- `flush_o` out 1 — squash IF/ID/EX contents.
- `jump_flag_o` out 1 — redirect PC this cycle.
- `jump_addr_o` out 32 — redirect target.
- `csr_we_o` out 1, `csr_waddr_o` out 12, `csr_wdata_o` out 32 — CSR write request, muxed ahead of WB's port.

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, WR_MRET, JUMP.
- Trigger evaluation happens in IDLE only, with inst_valid_i=1 and wb_csr_we_i=0. If wb_csr_we_i=1, evaluation is deferred; nothing is captured.
- Priority (highest first): ebreak (cause 3), ecall (cause 11), mret, external irq (cause 32'h8000000B), timer irq (cause 32'h80000007).
- Interrupts are accepted only when mstatus_i[3] (MIE)=1. Exceptions and mret ignore MIE.
- On accept, capture into registers: cause, pc=inst_addr_i, mstatus_i, mtvec_i, and an is_irq flag. The triggering instruction does not commit (hold_o then flush).
- mepc for both exceptions and interrupts = captured pc. Interrupted instruction re-executes after mret.
- Trap path: IDLE→WR_MEPC→WR_MCAUSE→WR_MSTATUS→JUMP→IDLE.
  - WR_MEPC writes addr 12'h341 with pc.
  - WR_MCAUSE writes 12'h342 with cause.
  - WR_MSTATUS writes 12'h300 with captured mstatus modified: bit7 (MPIE)←bit3, bit3←0, bits12:11 (MPP)←2'b11, other bits unchanged.
- Trap target: base={mtvec[31:2],2'b00}.
  - Vectored mode (mtvec[1:0]=01) with is_irq: target = base + 4×cause[4:0].
  - Otherwise: target = base.
  - Arithmetic is 32-bit; wraps modulo 2^32.
- mret path: IDLE→WR_MRET→JUMP→IDLE. WR_MRET writes 12'h300 with bit3←bit7, bit7←1, MPP←2'b11. JUMP target = mepc_i sampled in JUMP state, &~32'h3.
- mtvec[1:0] ∈ {10,11} is treated as direct mode.
- Interrupt requests arriving outside IDLE are not latched; they are re-evaluated in IDLE, gated by the new MIE.

## Timing
- Reset values: hold_o=0, flush_o=0, jump_flag_o=0, jump_addr_o=RESET_PC, csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, state=IDLE, captured registers 0.
- Accept cycle N (IDLE): hold_o=1 combinationally; nothing else is asserted.
- Trap: CSR writes are registered outputs in cycles N+1, N+2, N+3, one write per cycle. JUMP at N+4 asserts jump_flag_o=flush_o=1 for exactly one cycle with jump_addr_o valid. IDLE resumes at N+5. Total latency trigger→redirect is 4 cycles.
- mret: write at N+1, jump at N+2.
- hold_o=1 in every non-IDLE state; it is 0 in JUMP only if flush_o=1 (flush overrides hold).
- csr_we_o=1 only in WR_* states. csr_waddr_o/csr_wdata_o return to 0 elsewhere.
- Async reset mid-sequence: all outputs go to reset values immediately. Any partial CSR writes already issued stand. No redirect is issued.

## Test plan
- Ecall: ecall at pc 0x100, mtvec=0x200, mstatus=0x8 -> writes (0x341,0x100), (0x342,11), (0x300,0x1880); jump to 0x200 at N+4; hold high N..N+3.
- Vectored timer irq: MIE=1, mtvec=0x401, pc=0x80 -> mcause 0x80000007, jump 0x41C. With MIE=0, no response.
- Priority: ecall+irq_ext same cycle -> cause 11. mret+irq_timer same cycle -> mret path.
- Mret: mstatus=0x1880, mepc=0x104 -> write (0x300,0x1888) at N+1; jump 0x104 at N+2.
- CSR port busy: trigger with wb_csr_we_i=1 for 2 cycles -> no action; accept on first cycle with wb_csr_we_i=0.
- Reset asserted in WR_MCAUSE -> outputs zero asynchronously; after release, IDLE with no jump.
